mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single instruction/data memory port between instruction fetch (master 0, ifu) and data load/store (master 1, ex/lsu).
- Runs one transaction at a time through a three-state FSM. Data accesses have priority; an aging counter prevents fetch starvation.
- Drives a pipeline hold flag toward ex while a data access is pending or in flight.
- Sits between the ifu/ex request interfaces and the rom/ram slave port.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive lost arbitrations after which m0 is forced to win
- TIMEOUT_CYCLES, 16, cycles in RESP without a slave response before error termination

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- m0_addr_i  in  AW  fetch address
- m0_req_valid_i  in  1  fetch request valid
- m0_req_ready_o  out  1  fetch request accepted (combinational)
- m0_rdata_o  out  DW  fetch read data (registered)
- m0_rsp_valid_o  out  1  fetch response pulse
- m1_addr_i  in  AW  data address
- m1_wdata_i  in  DW  write data
- m1_we_i  in  1  1=write, 0=read
- m1_wstrb_i  in  DW/8  byte strobes
- m1_req_valid_i  in  1  data request valid
- m1_req_ready_o  out  1  data request accepted (combinational)
- m1_rdata_o  out  DW  data read data (registered)
- m1_rsp_valid_o  out  1  data response pulse
- s_addr_o  out  AW  slave address
- s_wdata_o  out  DW  slave write data
- s_we_o  out  1  slave write enable
- s_wstrb_o  out  DW/8  slave strobes
- s_req_valid_o  out  1  slave request valid
- s_req_ready_i  in  1  slave accepts request
- s_rdata_i  in  DW  slave read data
- s_rsp_valid_i  in  1  slave response valid
- bus_err_o  out  1  one-cycle pulse on timeout
- hold_flag_o  out  1  stall request to pipeline (combinational)

Behaviour:
- Reset values:
  - state = IDLE
  - all registered outputs = 0: s_*, m*_rdata_o, m*_rsp_valid_o, bus_err_o, owner, starve_cnt, timeout counter
- States:
  - IDLE
  - REQ: s_req_valid_o high
  - RESP: waiting for s_rsp_valid_i
- Handshake: a request is accepted on the cycle where valid & ready are both high.
  - m*_req_ready_o may be high only in IDLE, only for the winner, and never for both masters.
  - Masters hold addr/data stable while valid and not yet ready.
- Arbitration (IDLE only):
  - Only m1 valid → m1 wins.
  - Only m0 valid → m0 wins.
  - Both valid → m1 wins, unless starve_cnt == STARVE_LIMIT, in which case m0 wins.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each IDLE cycle where m0 is valid and m1 wins.
  - Clears when m0 is granted.
- On grant:
  - Capture addr, wdata, we and wstrb into the s_* registers.
  - For m0: we = 0, wstrb = 0.
  - owner <= winner; next state = REQ.
- REQ: s_req_valid_o = 1. When s_req_ready_i = 1: s_req_valid_o <= 0, timeout counter <= 0, state → RESP.
- RESP, on s_rsp_valid_i:
  - Register s_rdata_i into the owner's rdata.
  - Pulse the owner's rsp_valid_o on the next cycle.
  - State → IDLE.
  - Writes also complete on s_rsp_valid_i.
  - Non-owner rdata holds its last value.
- Latency: accept at T; s_req_valid_o high at T+1; with ready at T+1 and response at T+2, owner rsp_valid_o is high at T+3.
  - IDLE re-arbitrates in the same cycle rsp_valid_o is high, so the minimum spacing between back-to-back grants is 3 cycles.
- Timeout:
  - The timeout counter increments each RESP cycle.
  - On reaching TIMEOUT_CYCLES with no response: owner rsp_valid_o pulses with rdata = 0, bus_err_o pulses in the same cycle, state → IDLE.
  - REQ has no timeout.
- Stray responses: s_rsp_valid_i in IDLE or REQ is ignored.
- Simultaneous events: s_rsp_valid_i arriving on the same cycle the timeout is reached → the response wins, and no error is raised.
- hold_flag_o = (m1_req_valid_i & ~m1_req_ready_o) | (state != IDLE & owner == m1).
- Reset mid-transaction: all state returns to IDLE immediately and the in-flight transaction is dropped. No rsp_valid is issued for it.

Test Plan:
- Single fetch: m0 valid, addr=0x10 at T; slave ready at T+1, responds at T+2 with 0x00000013 → m0_req_ready_o=1 at T; m0_rsp_valid_o=1 and m0_rdata_o=0x00000013 at T+3; hold_flag_o=0 throughout.
- Write: m1 write addr=0x80, wdata=0xDEADBEEF, wstrb=0xF; slave ready immediately → s_we_o=1, s_wstrb_o=0xF, s_addr_o=0x80 while s_req_valid_o is high; hold_flag_o=1 until m1_rsp_valid_o.
- Contention/aging: m0 and m1 both held valid continuously, slave always ready with 1-cycle response → grant order m1,m1,m1,m1,m0,m1,…; starve_cnt returns to 0 after the m0 grant.
- Slave backpressure: s_req_ready_i low for 5 cycles in REQ → s_req_valid_o and s_addr_o stable; no timeout; completes normally.
- Timeout: m1 read, slave never responds → after 16 RESP cycles, m1_rsp_valid_o=1, m1_rdata_o=0 and bus_err_o=1 in the same cycle; state=IDLE.
- Reset mid-RESP: assert rst_n=0 while in RESP, then send a late s_rsp_valid_i after release → no rsp_valid on either master; all outputs 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave memory port arbiter.
// Master 0 is instruction fetch and master 1 is data load/store.
// Data accesses win arbitration, but an aging counter lets a starved fetch through.
// One transaction is in flight at a time.
// A response timeout ends a stuck access with rdata = 0 and a bus error pulse.
module mem_bus_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // master 0: instruction fetch
    input  logic [AW-1:0]   m0_addr_i,
    input  logic            m0_req_valid_i,
    output logic            m0_req_ready_o,
    output logic [DW-1:0]   m0_rdata_o,
    output logic            m0_rsp_valid_o,
    // master 1: data load/store
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_wstrb_i,
    input  logic            m1_req_valid_i,
    output logic            m1_req_ready_o,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            m1_rsp_valid_o,
    // slave port
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_wdata_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_wstrb_o,
    output logic            s_req_valid_o,
    input  logic            s_req_ready_i,
    input  logic [DW-1:0]   s_rdata_i,
    input  logic            s_rsp_valid_i,
    // status
    output logic            bus_err_o,
    output logic            hold_flag_o
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q,       state_d;
    logic            owner_q,       owner_d;      // 0 = m0, 1 = m1
    logic [SCW-1:0]  starve_cnt_q,  starve_cnt_d;
    logic [TCW-1:0]  tmo_cnt_q,     tmo_cnt_d;
    logic [AW-1:0]   s_addr_q,      s_addr_d;
    logic [DW-1:0]   s_wdata_q,     s_wdata_d;
    logic            s_we_q,        s_we_d;
    logic [SW-1:0]   s_wstrb_q,     s_wstrb_d;
    logic            s_req_valid_q, s_req_valid_d;
    logic [DW-1:0]   m0_rdata_q,    m0_rdata_d;
    logic [DW-1:0]   m1_rdata_q,    m1_rdata_d;
    logic            m0_rsp_valid_q, m0_rsp_valid_d;
    logic            m1_rsp_valid_q, m1_rsp_valid_d;
    logic            bus_err_q,     bus_err_d;

    logic            is_idle;
    logic            starve_at_limit;
    logic            win_m0;
    logic            win_m1;
    logic [TCW-1:0]  tmo_next;

    // Arbitration: data first, unless fetch has lost STARVE_LIMIT times in a row
    always_comb begin
        starve_at_limit = (starve_cnt_q == SCW'(STARVE_LIMIT));
        win_m1          = m1_req_valid_i && !(m0_req_valid_i && starve_at_limit);
        win_m0          = m0_req_valid_i && !win_m1;
    end

    assign is_idle        = (state_q == ST_IDLE);
    assign m0_req_ready_o = is_idle & win_m0;
    assign m1_req_ready_o = is_idle & win_m1;
    assign hold_flag_o    = (m1_req_valid_i & ~m1_req_ready_o) | (~is_idle & owner_q);
    assign tmo_next       = tmo_cnt_q + TCW'(1);

    // Next-state, slave request capture and response routing
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_cnt_d   = starve_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        s_addr_d       = s_addr_q;
        s_wdata_d      = s_wdata_q;
        s_we_d         = s_we_q;
        s_wstrb_d      = s_wstrb_q;
        s_req_valid_d  = s_req_valid_q;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;
        m0_rsp_valid_d = 1'b0;
        m1_rsp_valid_d = 1'b0;
        bus_err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_m1) begin
                    s_addr_d      = m1_addr_i;
                    s_wdata_d     = m1_wdata_i;
                    s_we_d        = m1_we_i;
                    s_wstrb_d     = m1_wstrb_i;
                    s_req_valid_d = 1'b1;
                    owner_d       = 1'b1;
                    state_d       = ST_REQ;
                    // m0 lost this round; m1 cannot win against m0 at the limit, so no overflow
                    if (m0_req_valid_i) begin
                        starve_cnt_d = starve_cnt_q + SCW'(1);
                    end
                end else if (win_m0) begin
                    s_addr_d      = m0_addr_i;
                    s_wdata_d     = '0;
                    s_we_d        = 1'b0;
                    s_wstrb_d     = '0;
                    s_req_valid_d = 1'b1;
                    owner_d       = 1'b0;
                    starve_cnt_d  = '0;
                    state_d       = ST_REQ;
                end
            end

            ST_REQ: begin
                if (s_req_ready_i) begin
                    s_req_valid_d = 1'b0;
                    tmo_cnt_d     = '0;
                    state_d       = ST_RESP;
                end
            end

            ST_RESP: begin
                // A response on the timeout cycle still counts as a normal completion
                if (s_rsp_valid_i) begin
                    if (owner_q) begin
                        m1_rdata_d     = s_rdata_i;
                        m1_rsp_valid_d = 1'b1;
                    end else begin
                        m0_rdata_d     = s_rdata_i;
                        m0_rsp_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (tmo_next == TCW'(TIMEOUT_CYCLES)) begin
                    if (owner_q) begin
                        m1_rdata_d     = '0;
                        m1_rsp_valid_d = 1'b1;
                    end else begin
                        m0_rdata_d     = '0;
                        m0_rsp_valid_d = 1'b1;
                    end
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_next;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            starve_cnt_q   <= '0;
            tmo_cnt_q      <= '0;
            s_addr_q       <= '0;
            s_wdata_q      <= '0;
            s_we_q         <= 1'b0;
            s_wstrb_q      <= '0;
            s_req_valid_q  <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
            m0_rsp_valid_q <= 1'b0;
            m1_rsp_valid_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            starve_cnt_q   <= starve_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            s_addr_q       <= s_addr_d;
            s_wdata_q      <= s_wdata_d;
            s_we_q         <= s_we_d;
            s_wstrb_q      <= s_wstrb_d;
            s_req_valid_q  <= s_req_valid_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
            m0_rsp_valid_q <= m0_rsp_valid_d;
            m1_rsp_valid_q <= m1_rsp_valid_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign s_addr_o       = s_addr_q;
    assign s_wdata_o      = s_wdata_q;
    assign s_we_o         = s_we_q;
    assign s_wstrb_o      = s_wstrb_q;
    assign s_req_valid_o  = s_req_valid_q;
    assign m0_rdata_o     = m0_rdata_q;
    assign m1_rdata_o     = m1_rdata_q;
    assign m0_rsp_valid_o = m0_rsp_valid_q;
    assign m1_rsp_valid_o = m1_rsp_valid_q;
    assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// It has a vector table for single transactions, a slave model, a response scoreboard,
// and directed sequences for contention, backpressure, timeout, stray responses and reset.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr_i;
    logic        m0_req_valid_i;
    logic        m0_req_ready_o;
    logic [31:0] m0_rdata_o;
    logic        m0_rsp_valid_o;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_we_i;
    logic [3:0]  m1_wstrb_i;
    logic        m1_req_valid_i;
    logic        m1_req_ready_o;
    logic [31:0] m1_rdata_o;
    logic        m1_rsp_valid_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic        s_we_o;
    logic [3:0]  s_wstrb_o;
    logic        s_req_valid_o;
    logic        s_req_ready_i;
    logic [31:0] s_rdata_i;
    logic        s_rsp_valid_i;
    logic        bus_err_o;
    logic        hold_flag_o;

    mem_bus_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(m0_addr_i), .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
        .m0_rdata_o(m0_rdata_o), .m0_rsp_valid_o(m0_rsp_valid_o),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_we_i(m1_we_i), .m1_wstrb_i(m1_wstrb_i),
        .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
        .m1_rdata_o(m1_rdata_o), .m1_rsp_valid_o(m1_rsp_valid_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_we_o(s_we_o), .s_wstrb_o(s_wstrb_o),
        .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
        .s_rdata_i(s_rdata_i), .s_rsp_valid_i(s_rsp_valid_i),
        .bus_err_o(bus_err_o), .hold_flag_o(hold_flag_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int rsp_cyc  = 0;

    // expected response record
    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    int          grant_log[$];
    int          grant_cyc[$];
    logic [31:0] last_rd[2];

    // slave model knobs
    logic        sl_enable = 1'b1;
    logic        sl_mute   = 1'b0;
    int          sl_ready_delay = 0;
    int          sl_rsp_delay   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_req_valid"}, 32'(s_req_valid_o), 32'd0);
        chk({tag, "_s_addr"},      s_addr_o,            32'd0);
        chk({tag, "_s_wdata"},     s_wdata_o,           32'd0);
        chk({tag, "_s_we"},        32'(s_we_o),         32'd0);
        chk({tag, "_s_wstrb"},     32'(s_wstrb_o),      32'd0);
        chk({tag, "_m0_rdata"},    m0_rdata_o,          32'd0);
        chk({tag, "_m1_rdata"},    m1_rdata_o,          32'd0);
        chk({tag, "_m0_rsp"},      32'(m0_rsp_valid_o), 32'd0);
        chk({tag, "_m1_rsp"},      32'(m1_rsp_valid_o), 32'd0);
        chk({tag, "_bus_err"},     32'(bus_err_o),      32'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Slave model: optional ready delay, fixed response delay, rdata = addr + 3
    int          sl_rw   = 0;
    int          sl_cnt  = 0;
    logic        sl_pend = 1'b0;
    logic [31:0] sl_addr = '0;
    initial begin
        s_req_ready_i = 1'b0;
        s_rsp_valid_i = 1'b0;
        s_rdata_i     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sl_pend = 1'b0;
                sl_rw   = 0;
                if (sl_enable) begin
                    s_req_ready_i = 1'b0;
                    s_rsp_valid_i = 1'b0;
                end
            end else if (sl_enable) begin
                s_req_ready_i = 1'b0;
                s_rsp_valid_i = 1'b0;
                if (sl_pend) begin
                    if (sl_cnt == 0) begin
                        sl_pend = 1'b0;
                        if (!sl_mute) begin
                            s_rsp_valid_i = 1'b1;
                            s_rdata_i     = sl_addr + 32'd3;
                        end
                    end else begin
                        sl_cnt--;
                    end
                end else if (s_req_valid_o) begin
                    if (sl_rw < sl_ready_delay) begin
                        sl_rw++;
                    end else begin
                        s_req_ready_i = 1'b1;
                        sl_rw   = 0;
                        sl_pend = 1'b1;
                        sl_cnt  = sl_rsp_delay;
                        sl_addr = s_addr_o;
                    end
                end
            end
        end
    end

    // Monitor: push expectations on accept, pop and compare on response
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (m0_req_ready_o || m1_req_ready_o)
                    chk("ready_exclusive", 32'(m0_req_ready_o & m1_req_ready_o), 32'd0);
                if (m0_req_valid_i && m0_req_ready_o) begin
                    exp_q.push_back('{m: 1'b0, rdata: sl_mute ? 32'd0 : m0_addr_i + 32'd3, err: sl_mute});
                    grant_log.push_back(0);
                    grant_cyc.push_back(cyc);
                    acc_cyc = cyc;
                end
                if (m1_req_valid_i && m1_req_ready_o) begin
                    exp_q.push_back('{m: 1'b1, rdata: sl_mute ? 32'd0 : m1_addr_i + 32'd3, err: sl_mute});
                    grant_log.push_back(1);
                    grant_cyc.push_back(cyc);
                    acc_cyc = cyc;
                end
                if (m0_rsp_valid_o || m1_rsp_valid_o || bus_err_o) begin
                    rsp_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_rsp actual m0=%0b m1=%0b err=%0b required none (cycle %0d)",
                                 m0_rsp_valid_o, m1_rsp_valid_o, bus_err_o, cyc);
                    end else begin
                        exp_t e;
                        int   own;
                        e   = exp_q.pop_front();
                        own = e.m ? 1 : 0;
                        chk("rsp_m0_valid", 32'(m0_rsp_valid_o), 32'(!e.m));
                        chk("rsp_m1_valid", 32'(m1_rsp_valid_o), 32'(e.m));
                        chk("rsp_rdata", e.m ? m1_rdata_o : m0_rdata_o, e.rdata);
                        chk("rsp_bus_err", 32'(bus_err_o), 32'(e.err));
                        chk("rsp_other_rdata_hold", e.m ? m0_rdata_o : m1_rdata_o, last_rd[1 - own]);
                        last_rd[own] = e.rdata;
                    end
                end
            end
        end
    end

    // single-transaction vectors issued from IDLE
    typedef struct {
        logic        m0_v;
        logic        m1_v;
        logic [31:0] m0_addr;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        m1_we;
        logic [3:0]  m1_wstrb;
        logic        exp_r0;
        logic        exp_r1;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[8];

    task automatic drive_m1(input logic v, input logic [31:0] a, input logic we);
        m1_req_valid_i = v;
        m1_addr_i      = a;
        m1_we_i        = we;
        m1_wdata_i     = 32'h5555_AAAA;
        m1_wstrb_i     = we ? 4'hF : 4'h0;
    endtask

    initial begin
        int          gl0;
        int          n;
        int          pat[10];
        logic [31:0] pat_v;

        // expected contention grant order, LSB first: m1 x4, m0, m1 x4, m0
        pat_v = 32'b1000010000;
        for (int i = 0; i < 10; i++) pat[i] = pat_v[i] ? 0 : 1;

        //          m0v   m1v   m0_addr  m1_addr  m1_wdata      we    strb  r0    r1    s_addr   s_wdata       s_we  s_wstrb
        vecs[0] = '{1'b1, 1'b0, 32'h10,  32'h0,   32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,   32'h200, 32'h1111_1111, 1'b0, 4'h0, 1'b0, 1'b1, 32'h200, 32'h1111_1111, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h0,   32'h80,  32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 1'b1, 32'h80,  32'hDEAD_BEEF, 1'b1, 4'hF};
        vecs[3] = '{1'b1, 1'b1, 32'h44,  32'h300, 32'h2222_2222, 1'b0, 4'h0, 1'b0, 1'b1, 32'h300, 32'h2222_2222, 1'b0, 4'h0};
        vecs[4] = '{1'b0, 1'b1, 32'h0,   32'h84,  32'h1234_5678, 1'b1, 4'h3, 1'b0, 1'b1, 32'h84,  32'h1234_5678, 1'b1, 4'h3};
        vecs[5] = '{1'b1, 1'b1, 32'h48,  32'h88,  32'hCAFE_F00D, 1'b1, 4'hC, 1'b0, 1'b1, 32'h88,  32'hCAFE_F00D, 1'b1, 4'hC};
        vecs[6] = '{1'b1, 1'b0, 32'h20,  32'h0,   32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 4'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 4'h0};

        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n = 1'b0;
        m0_req_valid_i = 1'b0;
        m0_addr_i = '0;
        drive_m1(1'b0, 32'h0, 1'b0);

        // reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        chk("reset_hold", 32'(hold_flag_o), 32'd0);
        rst_n = 1'b1;

        // table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            m0_req_valid_i = vecs[i].m0_v;
            m0_addr_i      = vecs[i].m0_addr;
            m1_req_valid_i = vecs[i].m1_v;
            m1_addr_i      = vecs[i].m1_addr;
            m1_wdata_i     = vecs[i].m1_wdata;
            m1_we_i        = vecs[i].m1_we;
            m1_wstrb_i     = vecs[i].m1_wstrb;
            @(negedge clk);
            chk($sformatf("v%0d_m0_ready", i), 32'(m0_req_ready_o), 32'(vecs[i].exp_r0));
            chk($sformatf("v%0d_m1_ready", i), 32'(m1_req_ready_o), 32'(vecs[i].exp_r1));
            chk($sformatf("v%0d_hold_idle", i), 32'(hold_flag_o), 32'd0);
            @(posedge clk); #1;
            m0_req_valid_i = 1'b0;
            m1_req_valid_i = 1'b0;
            if (vecs[i].exp_r0 || vecs[i].exp_r1) begin
                @(negedge clk);
                chk($sformatf("v%0d_s_req_valid", i), 32'(s_req_valid_o), 32'd1);
                chk($sformatf("v%0d_s_addr", i), s_addr_o, vecs[i].exp_addr);
                chk($sformatf("v%0d_s_we", i), 32'(s_we_o), 32'(vecs[i].exp_we));
                chk($sformatf("v%0d_s_wstrb", i), 32'(s_wstrb_o), 32'(vecs[i].exp_wstrb));
                if (vecs[i].exp_r1)
                    chk($sformatf("v%0d_s_wdata", i), s_wdata_o, vecs[i].exp_wdata);
                chk($sformatf("v%0d_hold_busy", i), 32'(hold_flag_o), 32'(vecs[i].exp_r1));
                wait_drain(40);
                chk($sformatf("v%0d_latency", i), 32'(rsp_cyc - acc_cyc), 32'd3);
            end
        end

        // contention: both masters held valid, aging lets m0 through every fifth grant
        @(posedge clk); #1;
        gl0 = grant_log.size();
        m0_req_valid_i = 1'b1;
        m0_addr_i      = 32'h1000;
        drive_m1(1'b1, 32'h2000, 1'b0);
        n = 0;
        while ((grant_log.size() - gl0) < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (m0_req_ready_o) begin
                chk("cont_hold_m1_waiting", 32'(hold_flag_o), 32'd1);
                chk("cont_m1_not_ready", 32'(m1_req_ready_o), 32'd0);
            end
        end
        @(posedge clk); #1;
        m0_req_valid_i = 1'b0;
        m1_req_valid_i = 1'b0;
        chk("cont_grant_count_reached", 32'((grant_log.size() - gl0) >= 10), 32'd1);
        if ((grant_log.size() - gl0) >= 10) begin
            for (int k = 0; k < 10; k++)
                chk($sformatf("cont_grant_%0d", k), 32'(grant_log[gl0 + k]), 32'(pat[k]));
            chk("cont_spacing", 32'(grant_cyc[gl0 + 1] - grant_cyc[gl0]), 32'd3);
        end
        wait_drain(40);

        // slave backpressure: ready held low for 5 REQ cycles
        sl_ready_delay = 5;
        @(posedge clk); #1;
        drive_m1(1'b1, 32'h400, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        m1_req_valid_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("bp_s_req_valid_%0d", k), 32'(s_req_valid_o), 32'd1);
            chk($sformatf("bp_s_addr_%0d", k), s_addr_o, 32'h400);
        end
        wait_drain(40);
        sl_ready_delay = 0;

        // timeout: slave accepts but never responds
        sl_mute = 1'b1;
        @(posedge clk); #1;
        drive_m1(1'b1, 32'h500, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        m1_req_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("tmo_hold_in_resp", 32'(hold_flag_o), 32'd1);
        wait_drain(40);
        chk("tmo_latency", 32'(rsp_cyc - acc_cyc), 32'd18);
        sl_mute = 1'b0;

        // response on the last RESP cycle before timeout completes normally
        sl_rsp_delay = 15;
        @(posedge clk); #1;
        m0_req_valid_i = 1'b1;
        m0_addr_i      = 32'h700;
        @(negedge clk);
        @(posedge clk); #1;
        m0_req_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_hold_m0_owner", 32'(hold_flag_o), 32'd0);
        wait_drain(40);
        chk("late_latency", 32'(rsp_cyc - acc_cyc), 32'd18);
        sl_rsp_delay = 0;

        // stray responses in IDLE and REQ are ignored
        @(posedge clk); #1;
        sl_enable = 1'b0;
        @(negedge clk);
        s_rsp_valid_i = 1'b1;
        s_rdata_i     = 32'h0000_0BAD;
        @(negedge clk);
        s_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("stray_idle_m0_rsp", 32'(m0_rsp_valid_o), 32'd0);
        chk("stray_idle_m1_rsp", 32'(m1_rsp_valid_o), 32'd0);
        @(posedge clk); #1;
        drive_m1(1'b1, 32'h800, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        m1_req_valid_i = 1'b0;
        @(negedge clk);
        s_rsp_valid_i = 1'b1;
        s_rdata_i     = 32'h0000_0BAD;
        s_req_ready_i = 1'b0;
        @(negedge clk);
        chk("stray_req_still_req", 32'(s_req_valid_o), 32'd1);
        s_rsp_valid_i = 1'b0;
        s_req_ready_i = 1'b1;
        @(negedge clk);
        chk("stray_req_moved_resp", 32'(s_req_valid_o), 32'd0);
        s_req_ready_i = 1'b0;
        s_rsp_valid_i = 1'b1;
        s_rdata_i     = 32'h803;
        @(negedge clk);
        s_rsp_valid_i = 1'b0;
        wait_drain(10);
        sl_enable = 1'b1;

        // reset in the middle of RESP drops the transaction
        sl_mute = 1'b1;
        @(posedge clk); #1;
        drive_m1(1'b1, 32'h900, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        m1_req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_hold_before", 32'(hold_flag_o), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        check_zero("rst_mid");
        chk("rst_mid_hold", 32'(hold_flag_o), 32'd0);
        sl_enable     = 1'b0;
        s_req_ready_i = 1'b0;
        s_rsp_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        sl_mute = 1'b0;
        @(negedge clk);
        s_rsp_valid_i = 1'b1;
        s_rdata_i     = 32'h1234_5678;
        @(negedge clk);
        s_rsp_valid_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_zero("post_rst");
        end

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    // Global bound on run time
    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
